fp_to_tc: RTL

- Decodes the 8-bit compressed floating-point word (sign, 3-bit exponent, 4-bit significand) back into a 12-bit two's-complement integer.
- It is the inverse path to the two's-complement→sign-magnitude→float encode chain, and it is used to check round-trips on hardware.
- Multi-cycle: the significand is expanded by an iterative shifter, one position per cycle, then negated if the sign is set.
- Valid/ready handshake on both the input and output sides.

---
 rtl/fp_to_tc.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fp_to_tc.sv
// fp_to_tc
// ---------------------------------------------------------------------------
// Decodes a compressed floating-point word (sign, EXP_W-bit exponent,
// FRAC_W-bit unsigned significand) into an OUT_W-bit two's-complement
// integer. The value is (-1)^S * F * 2^E.
//
// The significand is expanded by an iterative shifter that moves one bit
// position per clock. The result is then negated if the sign is set. This
// is the inverse of the two's-complement -> sign-magnitude -> float encode
// chain, and it is used to check round-trips on hardware.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   block can accept a word (high only in IDLE)
//   in_sign    sign bit, 1 = negative
//   in_exp     exponent E
//   in_frac    significand F (unsigned)
//   out_valid  result available (high only in DONE)
//   out_ready  consumer accepts the result
//   out_data   two's-complement result, held until the next result
//   busy       high in any state other than IDLE
//
// OUT_W must be at least FRAC_W + 2**EXP_W. With that width, the largest
// magnitude (15 * 128 with the default parameters) always fits, so no
// saturation logic is needed.
// ---------------------------------------------------------------------------
module fp_to_tc #(
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4,
  parameter int OUT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [OUT_W-1:0] OneOut = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] OneExp = {{(EXP_W-1){1'b0}}, 1'b1};

  state_e             state_q;
  logic [OUT_W-1:0]   mag_q;
  logic [EXP_W-1:0]   cnt_q;
  logic               sign_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   out_data_q;

  logic [OUT_W-1:0]   mag_shift_d;
  logic [EXP_W-1:0]   cnt_dec_d;
  logic [OUT_W-1:0]   result_d;

  // Datapath helpers feeding the FSM. A negative zero comes out as
  // ~0 + 1 = 0 after truncation, so it needs no special case.
  always_comb begin
    mag_shift_d = mag_q << 1;
    cnt_dec_d   = cnt_q - OneExp;
    result_d    = sign_q ? (~mag_q + OneOut) : mag_q;
  end

  // Control FSM and all registered state. The input is captured only in
  // IDLE. While a conversion is in flight, in_valid and the input fields
  // are ignored, and out_data holds its value after the handshake
  // completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            mag_q   <= {{(OUT_W-FRAC_W){1'b0}}, in_frac};
            cnt_q   <= in_exp;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            mag_q <= mag_shift_d;
            cnt_q <= cnt_dec_d;
          end else begin
            out_data_q  <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Every output is a register or a decode of the state register, so
  // there is no combinational path from any input to any output.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
